// File: rtl/multicycle_control_unit_if.sv
// Interface between the multicycle control unit and the MIPS datapath/memory.
// The master side is the control unit; the slave side is the datapath and memory.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
) ();
    logic             en;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_2_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state_o;
    logic             mem_err;
    logic [CNT_W-1:0] instr_retired;
    logic             trap;

    modport master (
        input  en, opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state_o, mem_err, instr_retired, trap
    );

    modport slave (
        output en, opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state_o, mem_err, instr_retired, trap
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath with memory timeout and retire counter.
// Define ILLEGAL_OP_TRAP_EN to send illegal opcodes to a sticky TRAP state instead of a NOP.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        arst_n,
    multicycle_control_unit_if.master   bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LIMIT  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        TRAP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_2_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       fetch;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.fetch = 1'b1; end
            DECODE:   c.alu_src_b = 2'd3;
            MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            MEM_WB:   begin c.mem_2_reg = 1'b1; c.reg_write = 1'b1; end
            MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            EXEC:     begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
            R_WB:     begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            ADDI_WB:  c.reg_write = 1'b1;
            BRANCH:   begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'd1;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'd1;
            end
            JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'd2; end
            default:  ;
        endcase
        return c;
    endfunction

    state_t             state;
    state_t             nxt;
    ctrl_t              ctrl_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   retired_q;
    logic               mem_err_q;
    logic               store_q;
    logic               waiting;
    logic               wait_hit;
    logic               timeout;
    logic               retire;
`ifdef ILLEGAL_OP_TRAP_EN
    logic               trap_q;
`endif

    assign waiting  = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign wait_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(LIMIT));

    // Next-state selection; timeout and retire are only raised while the datapath advances.
    always_comb begin
        nxt     = state;
        timeout = 1'b0;
        retire  = 1'b0;
        if (bus.en) begin
            case (state)
                FETCH: begin
                    if (bus.mem_ready) nxt = DECODE;
                    else if (wait_hit) begin nxt = FETCH; timeout = 1'b1; end
                end
                DECODE: begin
                    case (bus.opcode)
                        6'h00:        nxt = EXEC;
                        6'h08:        nxt = ADDI_EX;
                        6'h04:        nxt = BRANCH;
                        6'h02:        nxt = JUMP;
                        6'h23, 6'h2B: nxt = MEM_ADDR;
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            nxt = TRAP;
`else
                            nxt    = FETCH;
                            retire = 1'b1;
`endif
                        end
                    endcase
                end
                MEM_ADDR: nxt = store_q ? MEM_WR : MEM_RD;
                MEM_RD: begin
                    if (bus.mem_ready) nxt = MEM_WB;
                    else if (wait_hit) begin nxt = FETCH; timeout = 1'b1; end
                end
                MEM_WR: begin
                    if (bus.mem_ready) begin nxt = FETCH; retire = 1'b1; end
                    else if (wait_hit) begin nxt = FETCH; timeout = 1'b1; end
                end
                EXEC:    nxt = R_WB;
                ADDI_EX: nxt = ADDI_WB;
                MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: begin
                    nxt    = FETCH;
                    retire = 1'b1;
                end
                TRAP:    nxt = TRAP;
                default: nxt = FETCH;
            endcase
        end
    end

    // State, registered decode of the upcoming state, wait/retire counters and abort pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= FETCH;
            ctrl_q    <= decode(FETCH);
            wait_cnt  <= '0;
            retired_q <= '0;
            mem_err_q <= 1'b0;
            store_q   <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            mem_err_q <= timeout;
            if (bus.en) begin
                state  <= nxt;
                ctrl_q <= decode(nxt);
                if (state == DECODE) store_q <= (bus.opcode == 6'h2B);
                if ((nxt != state) || timeout) wait_cnt <= '0;
                else if (waiting && !bus.mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
                if (retire) retired_q <= retired_q + CNT_W'(1);
`ifdef ILLEGAL_OP_TRAP_EN
                trap_q <= (nxt == TRAP);
`endif
            end
        end
    end

    // Write strobes are suppressed during a stall; mux selects keep showing the state decode.
    assign bus.pc_write      = bus.en & (ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready));
    assign bus.pc_write_cond = bus.en & ctrl_q.pc_write_cond;
    assign bus.ir_write      = bus.en & ctrl_q.fetch & bus.mem_ready;
    assign bus.reg_write     = bus.en & ctrl_q.reg_write;
    assign bus.mem_write     = bus.en & ctrl_q.mem_write;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_2_reg     = ctrl_q.mem_2_reg;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.state_o       = state;
    assign bus.mem_err       = mem_err_q;
    assign bus.instr_retired = retired_q;
`ifdef ILLEGAL_OP_TRAP_EN
    assign bus.trap          = trap_q;
`else
    assign bus.trap          = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction flows, memory waits,
// timeout abort, datapath stall and illegal-opcode handling.
module tb_multicycle_control_unit;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic arst_n;
    int   checks   = 0;
    int   failures = 0;

    multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(
        .MEM_TIMEOUT (15),
        .CNT_W       (CNT_W)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [5:0] op, input logic rdy);
        bus.en        = en;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH with immediate memory response, then DECODE; leaves the bench in the dispatched state.
    task automatic fetchDecode(input logic [5:0] op);
        applyStimulus(1'b1, op, 1'b1);
        checkOutput("fetch_state", 32'(bus.state_o), 32'd0);
        checkOutput("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        checkOutput("fetch_pc_write", 32'(bus.pc_write), 32'd1);
        tick();
        checkOutput("decode_state", 32'(bus.state_o), 32'd1);
        checkOutput("decode_alu_src_b", 32'(bus.alu_src_b), 32'd3);
        tick();
    endtask

    initial begin
        arst_n = 1'b0;
        applyStimulus(1'b1, 6'h00, 1'b0);
        #10;
        checkOutput("rst_state", 32'(bus.state_o), 32'd0);
        checkOutput("rst_mem_read", 32'(bus.mem_read), 32'd1);
        checkOutput("rst_alu_src_b", 32'(bus.alu_src_b), 32'd1);
        checkOutput("rst_ir_write", 32'(bus.ir_write), 32'd0);
        checkOutput("rst_count", bus.instr_retired, 32'd0);
        checkOutput("rst_mem_err", 32'(bus.mem_err), 32'd0);
        checkOutput("rst_trap", 32'(bus.trap), 32'd0);
        arst_n = 1'b1;
        tick();

        // R-type
        fetchDecode(6'h00);
        checkOutput("exec_state", 32'(bus.state_o), 32'd6);
        checkOutput("exec_alu_op", 32'(bus.alu_op), 32'd2);
        checkOutput("exec_alu_src_a", 32'(bus.alu_src_a), 32'd1);
        tick();
        checkOutput("rwb_state", 32'(bus.state_o), 32'd7);
        checkOutput("rwb_reg_dst", 32'(bus.reg_dst), 32'd1);
        checkOutput("rwb_reg_write", 32'(bus.reg_write), 32'd1);
        tick();
        checkOutput("r_done_state", 32'(bus.state_o), 32'd0);
        checkOutput("r_count", bus.instr_retired, 32'd1);

        // LW with three wait cycles in MEM_RD
        fetchDecode(6'h23);
        checkOutput("lw_addr_state", 32'(bus.state_o), 32'd2);
        checkOutput("lw_addr_src_b", 32'(bus.alu_src_b), 32'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'h23, 1'b0);
            checkOutput("lw_rd_state", 32'(bus.state_o), 32'd3);
            checkOutput("lw_rd_i_or_d", 32'(bus.i_or_d), 32'd1);
            tick();
        end
        applyStimulus(1'b1, 6'h23, 1'b1);
        checkOutput("lw_rd_state_last", 32'(bus.state_o), 32'd3);
        checkOutput("lw_rd_mem_read", 32'(bus.mem_read), 32'd1);
        tick();
        checkOutput("lw_wb_state", 32'(bus.state_o), 32'd4);
        checkOutput("lw_wb_mem_2_reg", 32'(bus.mem_2_reg), 32'd1);
        checkOutput("lw_wb_reg_write", 32'(bus.reg_write), 32'd1);
        tick();
        checkOutput("lw_count", bus.instr_retired, 32'd2);

        // BEQ
        fetchDecode(6'h04);
        checkOutput("beq_state", 32'(bus.state_o), 32'd8);
        checkOutput("beq_pc_write_cond", 32'(bus.pc_write_cond), 32'd1);
        checkOutput("beq_pc_source", 32'(bus.pc_source), 32'd1);
        checkOutput("beq_alu_op", 32'(bus.alu_op), 32'd1);
        tick();
        checkOutput("beq_count", bus.instr_retired, 32'd3);

        // J
        fetchDecode(6'h02);
        checkOutput("j_state", 32'(bus.state_o), 32'd9);
        checkOutput("j_pc_write", 32'(bus.pc_write), 32'd1);
        checkOutput("j_pc_source", 32'(bus.pc_source), 32'd2);
        tick();
        checkOutput("j_count", bus.instr_retired, 32'd4);

        // ADDI
        fetchDecode(6'h08);
        checkOutput("addi_ex_state", 32'(bus.state_o), 32'd10);
        checkOutput("addi_ex_src_b", 32'(bus.alu_src_b), 32'd2);
        tick();
        checkOutput("addi_wb_state", 32'(bus.state_o), 32'd11);
        checkOutput("addi_wb_reg_write", 32'(bus.reg_write), 32'd1);
        checkOutput("addi_wb_reg_dst", 32'(bus.reg_dst), 32'd0);
        tick();
        checkOutput("addi_count", bus.instr_retired, 32'd5);

        // SW
        fetchDecode(6'h2B);
        checkOutput("sw_addr_state", 32'(bus.state_o), 32'd2);
        tick();
        checkOutput("sw_wr_state", 32'(bus.state_o), 32'd5);
        checkOutput("sw_mem_write", 32'(bus.mem_write), 32'd1);
        checkOutput("sw_i_or_d", 32'(bus.i_or_d), 32'd1);
        tick();
        checkOutput("sw_count", bus.instr_retired, 32'd6);

        // FETCH timeout after 15 cycles without mem_ready
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 6'h00, 1'b0);
            checkOutput("to_wait_state", 32'(bus.state_o), 32'd0);
            checkOutput("to_wait_mem_err", 32'(bus.mem_err), 32'd0);
            tick();
        end
        applyStimulus(1'b1, 6'h00, 1'b0);
        checkOutput("to_mem_err", 32'(bus.mem_err), 32'd1);
        checkOutput("to_state", 32'(bus.state_o), 32'd0);
        checkOutput("to_count", bus.instr_retired, 32'd6);
        tick();

        // mem_ready on the limit cycle completes normally
        for (int i = 1; i < 14; i++) begin
            applyStimulus(1'b1, 6'h00, 1'b0);
            checkOutput("lim_mem_err", 32'(bus.mem_err), 32'd0);
            tick();
        end
        applyStimulus(1'b1, 6'h00, 1'b1);
        checkOutput("lim_ir_write", 32'(bus.ir_write), 32'd1);
        tick();
        checkOutput("lim_state", 32'(bus.state_o), 32'd1);
        checkOutput("lim_mem_err", 32'(bus.mem_err), 32'd0);
        tick();
        checkOutput("lim_exec_state", 32'(bus.state_o), 32'd6);
        tick();

        // Stall in R_WB
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 6'h00, 1'b1);
            checkOutput("stall_state", 32'(bus.state_o), 32'd7);
            checkOutput("stall_reg_write", 32'(bus.reg_write), 32'd0);
            checkOutput("stall_reg_dst", 32'(bus.reg_dst), 32'd1);
            tick();
        end
        applyStimulus(1'b1, 6'h00, 1'b1);
        checkOutput("unstall_reg_write", 32'(bus.reg_write), 32'd1);
        tick();
        checkOutput("unstall_state", 32'(bus.state_o), 32'd0);
        checkOutput("unstall_count", bus.instr_retired, 32'd7);

        // Illegal opcode
        fetchDecode(6'h3F);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'h00, 1'b1);
            checkOutput("trap_state", 32'(bus.state_o), 32'd12);
            checkOutput("trap_flag", 32'(bus.trap), 32'd1);
            checkOutput("trap_mem_read", 32'(bus.mem_read), 32'd0);
            checkOutput("trap_pc_write", 32'(bus.pc_write), 32'd0);
            checkOutput("trap_count", bus.instr_retired, 32'd7);
            tick();
        end
        arst_n = 1'b0;
        #1;
        checkOutput("trap_rst_state", 32'(bus.state_o), 32'd0);
        checkOutput("trap_rst_flag", 32'(bus.trap), 32'd0);
        checkOutput("trap_rst_count", bus.instr_retired, 32'd0);
        #1;
        arst_n = 1'b1;
        tick();
`else
        applyStimulus(1'b1, 6'h00, 1'b1);
        checkOutput("illegal_state", 32'(bus.state_o), 32'd0);
        checkOutput("illegal_trap", 32'(bus.trap), 32'd0);
        checkOutput("illegal_count", bus.instr_retired, 32'd8);
`endif

        // Reset in the middle of an instruction abandons it
        fetchDecode(6'h00);
        checkOutput("mid_exec_state", 32'(bus.state_o), 32'd6);
        arst_n = 1'b0;
        #1;
        checkOutput("mid_rst_state", 32'(bus.state_o), 32'd0);
        checkOutput("mid_rst_count", bus.instr_retired, 32'd0);
        checkOutput("mid_rst_mem_read", 32'(bus.mem_read), 32'd1);
        #1;
        arst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
